// File: rtl/result_checker.sv
// Compares a unit-under-test result stream against a golden stream over a run of len samples,
// skipping LAT warm-up cycles, and keeps sticky error statistics plus the first mismatch.
module result_checker #(
    parameter int N   = 8,
    parameter int LAT = 1,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [CW-1:0] i_len,
    input  logic [N-1:0]  i_q_dut,
    input  logic [N-1:0]  i_q_ref,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [CW-1:0] o_err_count,
    output logic [CW-1:0] o_first_idx,
    output logic [N-1:0]  o_first_dut,
    output logic [N-1:0]  o_first_ref
);

    typedef enum logic [1:0] {IDLE, WARM, CHECK, DONE} state_t;

    localparam logic [3:0]    LAT_V = 4'(LAT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_warm;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_len;
    logic          r_error;
    logic [CW-1:0] r_err_count;
    logic [CW-1:0] r_first_idx;
    logic [N-1:0]  r_first_dut;
    logic [N-1:0]  r_first_ref;
    logic          w_accept;
    logic          w_compare;
    logic          w_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort has priority over comparison, so the sample on an abort cycle is never scored.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_compare = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    if (LAT_V != 4'd0) begin
                        w_next = WARM;
                    end else if (i_len == '0) begin
                        w_next = DONE;
                    end else begin
                        w_next = CHECK;
                    end
                end
            end
            WARM: begin
                if (i_abort) begin
                    w_next = IDLE;
                end else if (r_warm <= 4'd1) begin
                    w_next = (r_len == '0) ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (i_abort) begin
                    w_next = IDLE;
                end else begin
                    w_compare = 1'b1;
                    if (r_idx == r_len - ONE) begin
                        w_next = DONE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_mismatch = w_compare && (i_q_dut != i_q_ref);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm      <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_dut <= '0;
            r_first_ref <= '0;
        end else if (w_accept) begin
            r_warm      <= LAT_V;
            r_idx       <= '0;
            r_len       <= i_len;
            r_error     <= 1'b0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_dut <= '0;
            r_first_ref <= '0;
        end else begin
            if (r_state == WARM && !i_abort && r_warm != 4'd0) begin
                r_warm <= r_warm - 4'd1;
            end
            if (w_compare) begin
                r_idx <= r_idx + ONE;
            end
            // The first-mismatch snapshot is only taken while error is still clear.
            if (w_mismatch) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + ONE;
                end
                r_error <= 1'b1;
                if (!r_error) begin
                    r_first_idx <= r_idx;
                    r_first_dut <= i_q_dut;
                    r_first_ref <= i_q_ref;
                end
            end
        end
    end

    assign o_busy      = (r_state == WARM) || (r_state == CHECK);
    assign o_done      = (r_state == DONE);
    assign o_error     = r_error;
    assign o_err_count = r_err_count;
    assign o_first_idx = r_first_idx;
    assign o_first_dut = r_first_dut;
    assign o_first_ref = r_first_ref;

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter N, default 8: data width of the compared result buses.
REQ-002 Parameter LAT, default 1, legal 0..15: warm-up cycles skipped after start before comparison begins.
REQ-003 Parameter CW, default 16: width of the length, index and error counters.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a check run; honoured only in IDLE or DONE.
REQ-007 abort  input  1  terminates a run in progress.
REQ-008 len  input  CW  number of samples to compare; SHALL be sampled on the accepted start cycle.
REQ-009 q_dut  input  N  result from the unit under test.
REQ-010 q_ref  input  N  result from the golden model.
REQ-011 busy  output  1  high in WARM and CHECK.
REQ-012 done  output  1  high in DONE.
REQ-013 error  output  1  sticky: at least one mismatch occurred in the current or last run.
REQ-014 err_count  output  CW  mismatch count, saturating.
REQ-015 first_idx  output  CW  sample index of the first mismatch.
REQ-016 first_dut, first_ref  output  N each  q_dut and q_ref captured at the first mismatch.

Function
REQ-017 The state machine SHALL have the states IDLE, WARM, CHECK and DONE, all fully registered.
REQ-018 Accepting start SHALL clear error, err_count, first_idx, first_dut and first_ref, and SHALL latch len.
  - LAT>0: enter WARM with the warm counter = LAT.
  - LAT=0: enter CHECK directly.
REQ-019 WARM SHALL decrement the warm counter each cycle and move to CHECK on the cycle after it reaches 1; no comparison occurs in WARM.
REQ-020 In CHECK, each cycle SHALL compare q_dut against q_ref as sample number idx (0-based), then increment idx.
REQ-021 The state SHALL move to DONE after the sample with idx = len-1 is compared, giving exactly len compared cycles.
REQ-022 If the latched len is 0, the block SHALL move from the end of WARM (or from start when LAT=0) straight to DONE with no comparisons.
REQ-023 On a mismatch, err_count SHALL increment and saturate at 2^CW-1, and error SHALL set.
REQ-024 Only the first mismatch of a run SHALL load first_idx, first_dut and first_ref; later mismatches SHALL NOT overwrite them.
REQ-025 DONE SHALL hold done=1 and all statistics until the next accepted start.
REQ-026 start in DONE SHALL begin a new run in the same cycle that done drops.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in WARM or CHECK SHALL return the block to IDLE on the next edge.
  - Statistics gathered so far SHALL be retained.
  - done SHALL NOT assert.
  - The sample present on the abort cycle SHALL NOT be compared.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 start and abort in the same cycle: abort SHALL win when busy; otherwise start SHALL be accepted.
REQ-031 Statistics outputs SHALL reflect a comparison one cycle after the compared sample; done SHALL rise on the edge that registers the final comparison, so statistics are final when done=1.

Reset
REQ-032 rst_n=0 SHALL immediately force the following, regardless of clk, including mid-run:
  - state to IDLE;
  - busy, done and error to 0;
  - err_count, first_idx, first_dut, first_ref, the warm counter, idx and the latched len to 0.
REQ-033 The first rising clk edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-034 LAT=1, N=8, start with len=10, q_dut==q_ref on every cycle -> busy for 11 cycles, then done=1, error=0, err_count=0.
REQ-035 LAT=1, len=10, q_dut=q_ref^8'h01 on samples 3 and 7 only -> err_count=2, error=1, first_idx=3, first_dut and first_ref equal the sample-3 values.
REQ-036 CW=4, len=15, every sample mismatched -> err_count=4'hF, no wrap.
REQ-037 LAT=0, len=0 -> done=1 one cycle after start; err_count=0.
REQ-038 Abort at CHECK idx=4 after a mismatch at idx=2 -> IDLE next edge, done=0, error=1, err_count=1, first_idx=2; a start during the run is ignored.
REQ-039 rst_n pulsed low mid-CHECK between clock edges -> all outputs 0 immediately; a start right after release runs normally; start in DONE restarts with statistics cleared.
